pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch-PC generator. Successor to the single-register PC.
- Holds the architectural fetch PC and advances it sequentially by FETCH_BYTES.
- Arbitrates exception, return-from-exception (ertn) and N_REDIR branch/flush redirects by fixed priority.
- Buffers one redirect that arrives while fetch is stalled. Sits at the head of the IF stage and drives the instruction-memory address.

Parameters:
- PC_W, 32: PC width in bits.
- RESET_VEC, 32'h1c000000: PC value loaded on reset.
- FETCH_BYTES, 4: sequential increment. Power of two, at least 4.
- N_REDIR, 3: number of generic redirect sources. Index 0 has the highest priority among them.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  1 = hold PC (IF cannot accept).
- exc_valid  in  1  exception entry request.
- exc_target  in  PC_W  exception entry address.
- ertn_valid  in  1  exception-return request.
- ertn_target  in  PC_W  return address.
- redir_valid  in  N_REDIR  per-source redirect request.
- redir_target  in  N_REDIR*PC_W  packed targets; source i occupies bits [i*PC_W +: PC_W].
- pc  out  PC_W  current fetch PC.
- pc_valid  out  1  pc is a valid fetch address.
- seq_npc  out  PC_W  pc+FETCH_BYTES, combinational.
- pend_valid  out  1  a redirect is buffered.
- pc_adef  out  1  current pc is misaligned; only meaningful under PC_ALIGN_CHECK_EN, else tied 0.

Behaviour:
- Priority levels, highest first: exc (3), ertn (2), redir[0..N_REDIR-1] (1; lower index wins). The winning request in a cycle is "evt"; its level is "lvl".
- States:
  - BOOT: entered on reset.
  - RUN
  - PEND: a redirect is buffered.
- Reset (rst=1, any state, including mid-PEND): next edge gives pc=RESET_VEC, pc_valid=0, pend_valid=0, pc_adef=0, state BOOT. Pending target and level are cleared.
- BOOT: the first edge with rst=0 goes to RUN with pc_valid=1 and pc unchanged, so the first fetch is RESET_VEC. Redirects in this cycle are ignored.
- RUN:
  - evt and stall=0: pc <= evt target. Stay in RUN. Latency is 1 cycle from request to pc.
  - evt and stall=1: pend_tgt <= target, pend_lvl <= lvl, go to PEND. pc holds.
  - no evt and stall=0: pc <= pc+FETCH_BYTES, modulo 2^PC_W (wraps from all-ones region to 0).
  - no evt and stall=1: pc holds.
- PEND:
  - An evt with lvl >= pend_lvl replaces the buffer. Lower-level evt is dropped.
  - stall=0: pc <= the buffer value, or the same-cycle evt if it replaces the buffer. pend_valid drops, go to RUN.
  - No sequential increment occurs in PEND.
- Requests are level-sampled only on clock edges. The requester holds valid for one cycle; pc_gen does not acknowledge.
- seq_npc is always pc+FETCH_BYTES, truncated to PC_W.
- pend_valid is 1 exactly in PEND.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Targets are loaded unmodified.
  - pc_adef is registered alongside pc: 1 when the loaded pc has any of its low log2(FETCH_BYTES) bits set.
  - pc_adef is cleared by the next aligned load or by reset.
  - Sequential increments preserve the misalignment, so pc_adef stays 1.
- Undefined:
  - The low log2(FETCH_BYTES) bits of every loaded target are forced to 0.
  - pc_adef is tied 0.

Test Plan:
- Reset → pc=32'h1c000000 and pc_valid=0. Release rst → pc_valid=1 with pc still 32'h1c000000. Then 3 free cycles → pc = 1c000004, 1c000008, 1c00000c.
- redir_valid=3'b110 with targets 1000/2000/3000, stall=0 → next pc=2000 (index 1 beats index 2). exc_valid with redir_valid=3'b001 in the same cycle → pc=exc_target.
- stall=1 and redir[2]=4000 → pend_valid=1, pc holds. Next cycle ertn=5000, still stalled → buffer becomes 5000. Then redir[0]=6000, still stalled → dropped. Release stall → pc=5000, pend_valid=0.
- pc=32'hFFFFFFFC, no evt, stall=0 → pc=0.
- In PEND, assert rst → pc=1c000000, pend_valid=0, pc_valid=0. The buffered target never appears on pc.
- Redirect to 32'h1c000006: without the macro → pc=1c000004, pc_adef=0. With PC_ALIGN_CHECK_EN → pc=1c000006 and pc_adef=1. A later redirect to 1c000010 → pc_adef=0.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// pc_gen: fetch-PC generator with fixed-priority redirects and a one-entry stall buffer.
// Optional macro PC_ALIGN_CHECK_EN: misaligned targets are kept and flagged on pc_adef.
module pc_gen #(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_VEC   = 32'h1c000000,
  parameter int              FETCH_BYTES = 4,
  parameter int              N_REDIR     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    exc_valid,
  input  logic [PC_W-1:0]         exc_target,
  input  logic                    ertn_valid,
  input  logic [PC_W-1:0]         ertn_target,
  input  logic [N_REDIR-1:0]      redir_valid,
  input  logic [N_REDIR*PC_W-1:0] redir_target,
  output logic [PC_W-1:0]         pc,
  output logic                    pc_valid,
  output logic [PC_W-1:0]         seq_npc,
  output logic                    pend_valid,
  output logic                    pc_adef
);

  localparam logic [PC_W-1:0] STEP = PC_W'(FETCH_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] pend_tgt, pend_tgt_nx;
  logic [1:0]      pend_lvl, pend_lvl_nx;
  logic [PC_W-1:0] evt_tgt;
  logic [1:0]      evt_lvl;
  logic            evt;

`ifdef PC_ALIGN_CHECK_EN
  localparam int OFF_W = $clog2(FETCH_BYTES);

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] t);
    return t;
  endfunction
`else
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - PC_W'(1));

  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] t);
    return t & ALIGN_MASK;
  endfunction
`endif

  // Later assignments win: scan redirects from lowest priority up, then ertn, then exc.
  always_comb begin
    evt_lvl = 2'd0;
    evt_tgt = '0;
    for (int i = N_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        evt_lvl = 2'd1;
        evt_tgt = redir_target[i*PC_W +: PC_W];
      end
    end
    if (ertn_valid) begin
      evt_lvl = 2'd2;
      evt_tgt = ertn_target;
    end
    if (exc_valid) begin
      evt_lvl = 2'd3;
      evt_tgt = exc_target;
    end
  end

  assign evt = (evt_lvl != 2'd0);

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pend_tgt_nx = pend_tgt;
    pend_lvl_nx = pend_lvl;
    case (state)
      S_BOOT: state_nx = S_RUN;
      S_RUN: begin
        if (evt && stall) begin
          pend_tgt_nx = evt_tgt;
          pend_lvl_nx = evt_lvl;
          state_nx    = S_PEND;
        end else if (evt) begin
          pc_nx = align(evt_tgt);
        end else if (!stall) begin
          pc_nx = seq_npc;
        end
      end
      S_PEND: begin
        // Equal-or-higher level replaces the buffer; lower level is dropped.
        if (evt && (evt_lvl >= pend_lvl)) begin
          pend_tgt_nx = evt_tgt;
          pend_lvl_nx = evt_lvl;
        end
        if (!stall) begin
          pc_nx    = align(pend_tgt_nx);
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_BOOT;
      pc       <= RESET_VEC;
      pend_tgt <= '0;
      pend_lvl <= 2'd0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pend_tgt <= pend_tgt_nx;
      pend_lvl <= pend_lvl_nx;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sequential steps keep the low bits, so the flag tracks every pc update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_adef <= 1'b0;
    end else begin
      pc_adef <= |pc_nx[OFF_W-1:0];
    end
  end
`else
  assign pc_adef = 1'b0;
`endif

  assign seq_npc    = pc + STEP;
  assign pc_valid   = (state != S_BOOT);
  assign pend_valid = (state == S_PEND);

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// tb_pc_gen: directed test-plan steps followed by random traffic checked against a reference model.
module tb_pc_gen;

  localparam int          N  = 3;
  localparam logic [31:0] RV = 32'h1c000000;

  logic          clk = 1'b0;
  logic          rst, stall, exc_valid, ertn_valid;
  logic [31:0]   exc_target, ertn_target;
  logic [N-1:0]  redir_valid;
  logic [N*32-1:0] redir_target;
  logic [31:0]   pc, seq_npc;
  logic          pc_valid, pend_valid, pc_adef;

  int total  = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] m_pc, m_ptgt;
  bit          m_valid, m_pend;
  int          m_plvl;

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .exc_valid    (exc_valid),
    .exc_target   (exc_target),
    .ertn_valid   (ertn_valid),
    .ertn_target  (ertn_target),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .seq_npc      (seq_npc),
    .pend_valid   (pend_valid),
    .pc_adef      (pc_adef)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Model: computes the next architectural state from this cycle's inputs.
  task automatic model_step();
    bit          have = 0;
    logic [31:0] t = 32'h0;
    int          l = 0;
    if (exc_valid) begin
      have = 1; t = exc_target; l = 3;
    end else if (ertn_valid) begin
      have = 1; t = ertn_target; l = 2;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!have && redir_valid[i]) begin
          have = 1; t = redir_target[i*32 +: 32]; l = 1;
        end
      end
    end
    if (rst) begin
      m_pc = RV; m_valid = 0; m_pend = 0; m_ptgt = 0; m_plvl = 0;
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (!m_pend) begin
      if (have && stall) begin
        m_pend = 1; m_ptgt = t; m_plvl = l;
      end else if (have) begin
        m_pc = fix(t);
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (have && l >= m_plvl) begin
        m_ptgt = t; m_plvl = l;
      end
      if (!stall) begin
        m_pc = fix(m_ptgt); m_pend = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_adef;
`ifdef PC_ALIGN_CHECK_EN
    exp_adef = {31'b0, (m_pc[1:0] != 2'b00)};
`else
    exp_adef = 32'h0;
`endif
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_valid});
    chk({tag, ".pend_valid"}, {31'b0, pend_valid}, {31'b0, m_pend});
    chk({tag, ".seq_npc"}, seq_npc, m_pc + 32'd4);
    chk({tag, ".pc_adef"}, {31'b0, pc_adef}, exp_adef);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    rst = 0; stall = 0; exc_valid = 0; ertn_valid = 0; redir_valid = '0;
  endtask

  task automatic want(input string tag, input logic [31:0] p, input bit v, input bit pd);
    chk({tag, ".pc_const"}, pc, p);
    chk({tag, ".valid_const"}, {31'b0, pc_valid}, {31'b0, v});
    chk({tag, ".pend_const"}, {31'b0, pend_valid}, {31'b0, pd});
  endtask

  initial begin
    idle();
    exc_target = 0; ertn_target = 0; redir_target = '0;
    m_pc = 0; m_ptgt = 0; m_valid = 0; m_pend = 0; m_plvl = 0;

    // Reset and boot
    rst = 1;
    cycle("reset0");
    cycle("reset1");
    want("reset", RV, 0, 0);
    idle();
    cycle("boot");
    want("boot", RV, 1, 0);
    cycle("seq1"); want("seq1", 32'h1c000004, 1, 0);
    cycle("seq2"); want("seq2", 32'h1c000008, 1, 0);
    cycle("seq3"); want("seq3", 32'h1c00000c, 1, 0);

    // Redirect priority
    redir_target = {32'h3000, 32'h2000, 32'h1000};
    redir_valid  = 3'b110;
    cycle("redir_prio"); want("redir_prio", 32'h2000, 1, 0);
    redir_valid = 3'b001; exc_valid = 1; exc_target = 32'h7000;
    cycle("exc_prio"); want("exc_prio", 32'h7000, 1, 0);

    // Stall buffering: replace by ertn, drop lower-level redir
    idle(); stall = 1;
    redir_target[2*32 +: 32] = 32'h4000; redir_valid = 3'b100;
    cycle("pend_enter"); want("pend_enter", 32'h7000, 1, 1);
    redir_valid = '0; ertn_valid = 1; ertn_target = 32'h5000;
    cycle("pend_ertn"); want("pend_ertn", 32'h7000, 1, 1);
    ertn_valid = 0; redir_target[31:0] = 32'h6000; redir_valid = 3'b001;
    cycle("pend_drop"); want("pend_drop", 32'h7000, 1, 1);
    idle();
    cycle("pend_release"); want("pend_release", 32'h5000, 1, 0);

    // Wrap-around
    redir_target[31:0] = 32'hFFFFFFFC; redir_valid = 3'b001;
    cycle("to_top"); want("to_top", 32'hFFFFFFFC, 1, 0);
    idle();
    cycle("wrap"); want("wrap", 32'h0, 1, 0);

    // Reset while pending
    stall = 1; redir_target[63:32] = 32'hABC0; redir_valid = 3'b010;
    cycle("pend_before_rst"); want("pend_before_rst", 32'h0, 1, 1);
    idle(); rst = 1;
    cycle("rst_in_pend"); want("rst_in_pend", RV, 0, 0);
    idle();
    cycle("reboot"); want("reboot", RV, 1, 0);
    cycle("reboot_seq"); want("reboot_seq", 32'h1c000004, 1, 0);

    // Misaligned target
    redir_target[31:0] = 32'h1c000006; redir_valid = 3'b001;
    cycle("misalign");
`ifdef PC_ALIGN_CHECK_EN
    want("misalign", 32'h1c000006, 1, 0);
    chk("misalign.adef_const", {31'b0, pc_adef}, 32'h1);
`else
    want("misalign", 32'h1c000004, 1, 0);
    chk("misalign.adef_const", {31'b0, pc_adef}, 32'h0);
`endif
    idle();
    cycle("misalign_seq");
    redir_target[31:0] = 32'h1c000010; redir_valid = 3'b001;
    cycle("realign"); want("realign", 32'h1c000010, 1, 0);
    chk("realign.adef_const", {31'b0, pc_adef}, 32'h0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rst         = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 9) < 4);
      exc_valid   = ($urandom_range(0, 9) == 0);
      ertn_valid  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) redir_valid[i] = ($urandom_range(0, 4) == 0);
      exc_target  = $urandom;
      ertn_target = $urandom;
      for (int i = 0; i < N; i++) begin
        redir_target[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                                : $urandom;
      end
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
